// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID-stage operand/dest info,
// branch/memory status in, stall/flush/freeze controls and stall count out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic [REG_W-1:0] id_dest;
  logic             br_taken;
  logic             mem_ready;
  logic             hazard_stall;
  logic             flush_id;
  logic             flush_if;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en,
           id_dest, br_taken, mem_ready,
    input  hazard_stall, flush_id, flush_if, pipe_freeze, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en,
           id_dest, br_taken, mem_ready,
    output hazard_stall, flush_id, flush_if, pipe_freeze, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM destination scoreboard, RAW stall,
// branch flush and memory-wait freeze. Define FORWARDING_EN for load-use-only stalls.
module pipe_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, HAZ, MWAIT} state_t;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] dest;
  } slot_t;

  state_t           state_q, state_d;
  slot_t            ex_q, mem_q, id_slot;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_ex1, hit_ex2;
  logic             raw_hazard;
  logic             stall, fid, fif, freeze;
  logic             unused_slot;

  assign id_slot.valid    = 1'b1;
  assign id_slot.wb_en    = bus.id_wb_en;
  assign id_slot.mem_r_en = bus.id_mem_r_en;
  assign id_slot.dest     = bus.id_dest;

  assign hit_ex1 = ex_q.valid && ex_q.wb_en && (ex_q.dest == bus.id_src1);
  assign hit_ex2 = ex_q.valid && ex_q.wb_en && bus.id_two_src &&
                   (ex_q.dest == bus.id_src2);

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time.
  assign raw_hazard = bus.id_valid && ex_q.mem_r_en && (hit_ex1 || hit_ex2);
`else
  logic hit_mem1, hit_mem2;
  assign hit_mem1 = mem_q.valid && mem_q.wb_en && (mem_q.dest == bus.id_src1);
  assign hit_mem2 = mem_q.valid && mem_q.wb_en && bus.id_two_src &&
                    (mem_q.dest == bus.id_src2);
  assign raw_hazard = bus.id_valid &&
                      (hit_ex1 || hit_ex2 || hit_mem1 || hit_mem2);
`endif

  // The MEM slot exists only to age entries out; some fields are never inspected.
  assign unused_slot = ^mem_q;

  always_comb begin
    stall   = 1'b0;
    fid     = 1'b0;
    fif     = 1'b0;
    freeze  = 1'b0;
    state_d = state_q;
    if (!rst) begin
      state_d = RUN;
    end else if (!bus.mem_ready) begin
      freeze  = 1'b1;
      state_d = MWAIT;
    end else if (bus.br_taken) begin
      fif     = 1'b1;
      fid     = 1'b1;
      state_d = RUN;
    end else if (raw_hazard) begin
      stall   = 1'b1;
      fid     = 1'b1;
      state_d = HAZ;
    end else begin
      state_d = RUN;
    end
  end

  assign bus.hazard_stall = stall;
  assign bus.flush_id     = fid;
  assign bus.flush_if     = fif;
  assign bus.pipe_freeze  = freeze;
  assign bus.stall_cnt    = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        ex_q  <= (bus.id_valid && !stall && !fid) ? id_slot : '0;
        mem_q <= ex_q;
      end
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
